// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if
// Bundles every non-clock signal of the shared-ALU scheduler.
//   Request side  : req_valid/req_ready per requester, with packed opcodes and operands.
//                   Requester i uses req_opcode[4i+3:4i], req_op1[8i+7:8i] and req_op2[8i+7:8i].
//   Response side : rsp_valid/rsp_ready handshake carrying rsp_id, rsp_result and rsp_err.
//   ALU side      : alu_enable/alu_opcode/alu_op1/alu_op2 out to the ALU, alu_result back in.
//   Status        : busy.
// The slave modport is the scheduler's view. The master modport is the view of the
// requesters, the response consumer and the ALU, taken together.
interface alu_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_opcode;
    logic [8*NREQ-1:0] req_op1;
    logic [8*NREQ-1:0] req_op2;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_result;
    logic              rsp_err;

    logic              alu_enable;
    logic [3:0]        alu_opcode;
    logic [7:0]        alu_op1;
    logic [7:0]        alu_op2;
    logic [15:0]       alu_result;

    logic              busy;

    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_enable, alu_opcode, alu_op1, alu_op2, busy
    );

    modport master (
        output req_valid, req_opcode, req_op1, req_op2, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_enable, alu_opcode, alu_op1, alu_op2, busy
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
// Shares one combinational 8-bit ALU between NREQ requesters.
// Requests are picked round-robin, starting from the requester after the last winner.
// The winner's opcode and operands are registered and drive the ALU for one ISSUE cycle.
// The ALU result is then captured and returned on a single response channel, tagged
// with the winner's index. Only one operation is in flight at a time.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_rr_scheduler_if.slave (request, response, ALU drive and busy signals)
module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_rr_scheduler_if.slave    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]      state_q,      state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  id_q,         id_d;
    logic            alu_enable_q, alu_enable_d;
    logic [3:0]      alu_opcode_q, alu_opcode_d;
    logic [7:0]      alu_op1_q,    alu_op1_d;
    logic [7:0]      alu_op2_q,    alu_op2_d;
    logic            rsp_valid_q,  rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q,     rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            rsp_err_q,    rsp_err_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand_idx;
    logic [NREQ-1:0] grant_onehot;
    logic [3:0]      win_opcode;
    logic [7:0]      win_op1;
    logic [7:0]      win_op2;

    // Round-robin search: scan upward from last_grant+1, wrapping modulo NREQ.
    // The first valid requester found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign win_opcode = bus.req_opcode[{grant_idx, 2'b00} +: 4];
    assign win_op1    = bus.req_op1[{grant_idx, 3'b000} +: 8];
    assign win_op2    = bus.req_op2[{grant_idx, 3'b000} +: 8];

    // Ready is only offered in IDLE. It is gated by rst_n so that nothing
    // appears to be accepted while the block is held in reset.
    always_comb begin
        grant_onehot = '0;
        if (rst_n && state_q == ST_IDLE && grant_found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    // Next-state and datapath update for the IDLE -> ISSUE -> RESP cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_enable_d = alu_enable_q;
        alu_opcode_d = alu_opcode_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    alu_opcode_d = win_opcode;
                    alu_op1_d    = win_op1;
                    alu_op2_d    = win_op2;
                    alu_enable_d = 1'b1;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Opcodes 1010/1011 are unsupported by the ALU. The result is
                // still captured, and the error flag marks it.
                rsp_result_d = bus.alu_result;
                rsp_err_d    = (alu_opcode_q == 4'b1010) || (alu_opcode_q == 4'b1011);
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                alu_enable_d = 1'b0;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state clears immediately on reset. The pointer resets to NREQ-1,
    // so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            alu_enable_q <= 1'b0;
            alu_opcode_q <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_enable_q <= alu_enable_d;
            alu_opcode_q <= alu_opcode_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = grant_onehot;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_enable = alu_enable_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_op1    = alu_op1_q;
    assign bus.alu_op2    = alu_op2_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler
// Testbench for alu_rr_scheduler.
// Drives four requesters and models the external ALU.
// A scoreboard queue holds the expected response for every accepted request.
// Each response is popped from the queue and checked when its handshake happens.
// Ports: none (top-level bench).
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus();

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        logic [3:0]  opcode;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [15:0] exp_result;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    result;
        logic           err;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // External ALU model.
    // NOT returns both inverted operands side by side.
    // Arithmetic results are 8 bits wide, except ADD, which keeps its carry bit,
    // and MUL, which returns the full 16-bit product.
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                               input logic [7:0] b);
        logic [15:0] r;
        case (op)
            4'b0000: r = {~a, ~b};
            4'b0001: r = {8'h00, a & b};
            4'b0011: r = {8'h00, a ^ b};
            4'b0100: r = {7'b0, {1'b0, a} + {1'b0, b}};
            4'b0101: r = {8'h00, 8'(a - b)};
            4'b0110: r = 16'(a) * 16'(b);
            4'b1101: r = {8'h00, 8'(a + 8'h01)};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // A disabled ALU returns a marker value.
    // A capture outside the ISSUE cycle is then visible in the result.
    always_comb begin
        bus.alu_result = bus.alu_enable ? alu_model(bus.alu_opcode, bus.alu_op1, bus.alu_op2)
                                        : 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int id, input logic [15:0] result, input logic err);
        exp_t e;
        e.id     = IDW'(id);
        e.result = result;
        e.err    = err;
        sb_q.push_back(e);
    endtask

    task automatic setReq(input int id, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b);
        bus.req_opcode[4*id +: 4] = op;
        bus.req_op1[8*id +: 8]    = a;
        bus.req_op2[8*id +: 8]    = b;
    endtask

    function automatic int onehotIndex(input logic [NREQ-1:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // Pops the oldest expected response and compares it with the response
    // being handed over.
    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_rsp: got id %0d result 'h%0h, expected no response",
                     bus.rsp_id, bus.rsp_result);
        end else begin
            e = sb_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_result", 32'(bus.rsp_result), 32'(e.result));
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
    endtask

    // Response monitor. Sampling at negedge sees the handshake about to complete.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) checkOutput();
    end

    // Raises one request and waits (bounded) for its ready.
    // Called from an idle scheduler, so ready must appear in the same cycle.
    task automatic applyStimulus(input vec_t v);
        int  waited;
        bit  seen;
        setReq(v.id, v.opcode, v.op1, v.op2);
        bus.req_valid[v.id] = 1'b1;
        seen   = 1'b0;
        waited = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.req_ready[v.id]) seen = 1'b1;
            else waited++;
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: got no ready for requester %0d, expected ready",
                     v.id);
        end else begin
            check("ready_same_cycle", 32'(waited), 32'd0);
            check("ready_onehot", 32'(bus.req_ready), 32'(1 << v.id));
            pushExp(v.id, v.exp_result, v.exp_err);
        end
        @(posedge clk);
        #1;
        bus.req_valid[v.id] = 1'b0;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            if (sb_q.size() == 0 && !bus.rsp_valid && !bus.busy) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0",
                     sb_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   grants[$];
        int   gcyc[$];
        int   rr_exp[5];
        int   id;
        bit   got_rsp;

        vecs[0] = '{id: 0, opcode: 4'b0100, op1: 8'h05, op2: 8'h03, exp_result: 16'h0008, exp_err: 1'b0};
        vecs[1] = '{id: 2, opcode: 4'b0000, op1: 8'hF0, op2: 8'h0F, exp_result: 16'h0FF0, exp_err: 1'b0};
        vecs[2] = '{id: 1, opcode: 4'b1010, op1: 8'h12, op2: 8'h34, exp_result: 16'h0000, exp_err: 1'b1};
        vecs[3] = '{id: 3, opcode: 4'b1011, op1: 8'h55, op2: 8'h66, exp_result: 16'h0000, exp_err: 1'b1};
        vecs[4] = '{id: 3, opcode: 4'b0101, op1: 8'h03, op2: 8'h05, exp_result: 16'h00FE, exp_err: 1'b0};
        vecs[5] = '{id: 1, opcode: 4'b0100, op1: 8'hFF, op2: 8'h01, exp_result: 16'h0100, exp_err: 1'b0};
        vecs[6] = '{id: 2, opcode: 4'b1101, op1: 8'hFF, op2: 8'h00, exp_result: 16'h0000, exp_err: 1'b0};
        vecs[7] = '{id: 0, opcode: 4'b0110, op1: 8'h0C, op2: 8'h0D, exp_result: 16'h009C, exp_err: 1'b0};
        rr_exp = '{0, 1, 2, 3, 0};

        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.rsp_ready  = 1'b0;

        // Reset state, with every requester pending so that the forced-low ready is exercised.
        bus.req_valid = '1;
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
        check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        check("rst_alu_op1", 32'(bus.alu_op1), 32'd0);
        check("rst_alu_op2", 32'(bus.alu_op2), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;

        // Single ADD: accepted at edge T, rsp_valid rises at edge T+1.
        v = vecs[0];
        applyStimulus(v);
        check("add_rsp_not_early", 32'(bus.rsp_valid), 32'd0);
        check("add_busy_issue", 32'(bus.busy), 32'd1);
        check("add_alu_enable", 32'(bus.alu_enable), 32'd1);
        check("add_alu_op1", 32'(bus.alu_op1), 32'h05);
        @(posedge clk);
        #1;
        check("add_rsp_latency", 32'(bus.rsp_valid), 32'd1);
        check("add_alu_disabled", 32'(bus.alu_enable), 32'd0);
        waitDrain();

        // Table-driven single operations.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            waitDrain();
        end

        // Backpressure: the response is held stable and no request is accepted.
        bus.rsp_ready = 1'b0;
        v = '{id: 0, opcode: 4'b0101, op1: 8'h03, op2: 8'h05, exp_result: 16'h00FE, exp_err: 1'b0};
        applyStimulus(v);
        @(posedge clk);
        #1;
        setReq(1, 4'b0100, 8'h01, 8'h02);
        bus.req_valid[1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(bus.rsp_result), 32'h00FE);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_same_cycle_accept", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_accept_after_release", 32'(bus.req_ready), 32'b0010);
        if (bus.req_ready[1]) pushExp(1, 16'h0003, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        waitDrain();

        // Round-robin with all requesters continuously valid, starting from a fresh pointer.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) setReq(i, 4'b1101, 8'hFF, 8'h00);
        bus.req_valid = '1;
        for (int c = 0; c < 40 && grants.size() < 5; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                check("rr_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                id = onehotIndex(bus.req_ready);
                grants.push_back(id);
                gcyc.push_back(c);
                pushExp(id, 16'h0000, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("rr_grant_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < grants.size(); i++) begin
            check("rr_order", 32'(grants[i]), 32'(rr_exp[i]));
            if (i > 0) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        waitDrain();

        // Reset while a response is pending: it is discarded and the pointer restarts at 0.
        bus.rsp_ready = 1'b0;
        v = '{id: 2, opcode: 4'b0000, op1: 8'hF0, op2: 8'h0F, exp_result: 16'h0FF0, exp_err: 1'b0};
        applyStimulus(v);
        got_rsp = 1'b0;
        for (int c = 0; c < 10 && !got_rsp; c++) begin
            if (bus.rsp_valid) got_rsp = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rr_pending_rsp", 32'(got_rsp), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        sb_q.delete();
        setReq(1, 4'b0100, 8'h10, 8'h20);
        setReq(3, 4'b0100, 8'h07, 8'h08);
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        grants.delete();
        for (int c = 0; c < 30 && grants.size() < 2; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                id = onehotIndex(bus.req_ready);
                grants.push_back(id);
                pushExp(id, (id == 1) ? 16'h0030 : 16'h000F, 1'b0);
                @(posedge clk);
                #1;
                if (id >= 0) bus.req_valid[id] = 1'b0;
            end
        end
        check("post_rst_grant_count", 32'(grants.size()), 32'd2);
        if (grants.size() > 0) check("post_rst_first_grant", 32'(grants[0]), 32'd1);
        if (grants.size() > 1) check("post_rst_second_grant", 32'(grants[1]), 32'd3);
        bus.req_valid = '0;
        waitDrain();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 8-bit ALU (opcode-based, 16-bit result) between NREQ requesters.
- Each requester holds a valid/ready request until the scheduler accepts it.
- The scheduler arbitrates round-robin, drives the ALU from registered operands and captures the ALU result.
- The result is returned on a single valid/ready response channel, tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_opcode  input  4*NREQ  packed opcodes; requester i at [4i+3:4i].
- req_op1  input  8*NREQ  packed operand1; requester i at [8i+7:8i].
- req_op2  input  8*NREQ  packed operand2; requester i at [8i+7:8i].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_result  output  16  captured ALU result.
- rsp_err  output  1  opcode was 4'b1010 or 4'b1011 (unsupported).
- alu_enable  output  1  drives ALU enable.
- alu_opcode  output  4  drives ALU opcode.
- alu_op1  output  8  drives ALU operand1.
- alu_op2  output  8  drives ALU operand2.
- alu_result  input  16  ALU result; combinational and valid in the same cycle as its inputs.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock/reset: single clock clk. Reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n low.
- Reset values:
  - state=IDLE.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - alu_enable=0, alu_opcode=0, alu_op1=0, alu_op2=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - busy=0.
  - req_ready is combinational and forced to 0 while rst_n is low.
- FSM states IDLE, ISSUE, RESP:
  - IDLE: if any req_valid is high, the winner is the first set bit searching upward from last_grant+1, wrapping modulo NREQ.
    - req_ready[winner]=1 combinationally in this cycle only.
    - At the clock edge: latch the winner's opcode/op1/op2 into the alu_* registers; set alu_enable=1; set id=winner; set last_grant=winner; go to ISSUE.
    - If no req_valid, stay in IDLE with req_ready=0.
  - ISSUE (exactly one cycle): the ALU is driven from registers.
    - At the clock edge: rsp_result<=alu_result; rsp_err<=(opcode==4'b1010 || opcode==4'b1011); rsp_id<=id; rsp_valid<=1; alu_enable<=0; go to RESP.
    - For unsupported opcodes, rsp_result is whatever the ALU returns (16'h0000 from a correct ALU); rsp_err flags it.
  - RESP: rsp_valid, rsp_id, rsp_result and rsp_err are held stable until rsp_ready is sampled high.
    - On rsp_valid && rsp_ready at a clock edge: rsp_valid<=0 and go to IDLE.
    - rsp_result/rsp_id/rsp_err keep their last values after the handshake.
- req_ready is 0 in ISSUE and RESP; no request is accepted while a response is pending.
- Timing:
  - Accept at edge T (handshake cycle ending at T), rsp_valid high from edge T+1.
  - Minimum request-to-response latency 2 cycles after req_valid with the scheduler idle.
  - Maximum throughput 1 operation per 3 cycles.
- A requester must hold its valid, opcode and operands until it sees ready. The scheduler does not buffer unaccepted requests.
- A requester may drop req_valid before acceptance; it is then simply not selected.
- Fairness: every continuously valid requester is served within NREQ grants.
- Simultaneous rsp_ready with new req_valid in RESP: the handshake completes and the return to IDLE happens first. The new grant occurs in the following IDLE cycle (no same-cycle accept).
- Reset mid-operation (ISSUE or RESP): the in-flight operation is discarded, no response is produced, and the round-robin pointer returns to priority requester 0.
- alu_op1/alu_op2/alu_opcode hold their last values in IDLE/RESP; only alu_enable gates the ALU.

Test Plan:
- Single ADD: requester 0 sends opcode 4'b0100, op1=8'h05, op2=8'h03 -> req_ready[0] in the same cycle; 2 edges later rsp_valid=1, rsp_id=0, rsp_result=16'h0008, rsp_err=0.
- NOT split result: requester 2 sends opcode 4'b0000, op1=8'hF0, op2=8'h0F -> rsp_result=16'h0FF0, rsp_id=2.
- Round-robin with all 4 requesters valid continuously, rsp_ready=1, all sending INC (4'b1101) on op1=8'hFF -> grant order 0,1,2,3,0. Each rsp_result=16'h0000 (8-bit wrap). One grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after SUB (4'b0101), op1=8'h03, op2=8'h05 -> rsp_valid stays 1 with rsp_result=16'h00FE stable; all req_ready stay 0; one cycle after rsp_ready=1, IDLE accepts the next request.
- Unsupported opcode: requester 1 sends opcode 4'b1010 -> rsp_err=1, rsp_result=16'h0000, rsp_id=1.
- Reset in RESP: assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 and busy=0 immediately. After release with requesters 1 and 3 both valid, requester 1 is granted first.
